// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter between the CPU
// load/store port (C) and the DMA/debug loader port (D).
package dmem_arb_pkg;

  // IDLE arbitrates freely; DLOCK reserves the RAM for the remaining DMA burst beats
  typedef enum logic {
    IDLE  = 1'b0,
    DLOCK = 1'b1
  } arb_state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int MAX_WAIT_DEFAULT = 8;

  // Width of the starvation counter; holds any MAX_WAIT in 1..255
  localparam int WAIT_W = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/grant/read-data bundle for both RAM clients plus the RAM side.
// The slave modport is the arbiter's view. The master modport is the view
// of the surrounding system: the requesters and the RAM array.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 4
);
  logic              c_req;
  logic              c_we;
  logic [31:0]       c_addr;
  logic [31:0]       c_wdata;
  logic              c_gnt;
  logic              c_stall;
  logic [31:0]       c_rdata;
  logic              c_rvalid;

  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [LEN_W-1:0]  d_len;
  logic              d_gnt;
  logic [31:0]       d_rdata;
  logic              d_rvalid;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_stall, c_rdata, c_rvalid,
    input  d_req, d_we, d_addr, d_wdata, d_len,
    output d_gnt, d_rdata, d_rvalid,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_stall, c_rdata, c_rvalid,
    output d_req, d_we, d_addr, d_wdata, d_len,
    input  d_gnt, d_rdata, d_rvalid,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/dmem_arb_rdreg.sv
// Per-port read-data register. The RAM read is combinational, so the word
// is captured at the edge that ends a read grant and presented for exactly
// the following cycle.
module dmem_arb_rdreg (
  input  logic        clk,
  input  logic        rst,
  input  logic        gnt,
  input  logic        we,
  input  logic [31:0] ram_rdata,
  output logic [31:0] rdata,
  output logic        rvalid
);

  // Capture the read word on a granted read; writes and idle cycles drop rvalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= 32'd0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= gnt & ~we;
      if (gnt && !we) begin
        rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: fixed CPU priority, a DMA anti-starvation override after
// MAX_WAIT denied cycles, and DMA burst locking (d_len = beats - 1).
// Optional build macro DMEM_ARB_STATS_EN adds grant/conflict counters.
import dmem_arb_pkg::*;

module dmem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int LEN_W    = 4,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_c_grants,
  output logic [31:0] stat_d_grants,
  output logic [31:0] stat_conflicts
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  arb_state_t        state, state_nxt;
  logic [LEN_W-1:0]  beats_left, beats_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              c_gnt, d_gnt, sel;

  // Only the word-address bits reach the RAM; the rest wrap or select bytes
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.c_addr[31:ADDR_W+2], bus.c_addr[1:0],
                              bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};

  // State, remaining burst beats and DMA starvation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beats_left <= '0;
      wait_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      beats_left <= beats_nxt;
      wait_cnt   <= wait_nxt;
    end
  end

  // Grant decision and next state; nothing is granted while reset is held
  always_comb begin
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    state_nxt = state;
    beats_nxt = beats_left;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (bus.d_req && wait_cnt == WAIT_LIMIT) begin
            d_gnt = 1'b1;
          end else if (bus.c_req) begin
            c_gnt = 1'b1;
          end else if (bus.d_req) begin
            d_gnt = 1'b1;
          end
          if (d_gnt && bus.d_len != '0) begin
            beats_nxt = bus.d_len;
            state_nxt = DLOCK;
          end
        end
        DLOCK: begin
          if (bus.d_req) begin
            d_gnt     = 1'b1;
            beats_nxt = beats_left - LEN_W'(1);
            if (beats_left == LEN_W'(1)) begin
              state_nxt = IDLE;
            end
          end else if (bus.c_req) begin
            c_gnt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Starvation counter saturates while DMA is refused, clears otherwise
  always_comb begin
    wait_nxt = '0;
    if (bus.d_req && !d_gnt) begin
      wait_nxt = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + WAIT_W'(1);
    end
  end

  // Route the granted port onto the RAM bus; all zero when idle
  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = 32'd0;
    sel           = d_gnt ? PORT_D : PORT_C;
    if (c_gnt || d_gnt) begin
      bus.ram_en = 1'b1;
      if (sel == PORT_D) begin
        bus.ram_we    = bus.d_we;
        bus.ram_addr  = bus.d_addr[ADDR_W+1:2];
        bus.ram_wdata = bus.d_wdata;
      end else begin
        bus.ram_we    = bus.c_we;
        bus.ram_addr  = bus.c_addr[ADDR_W+1:2];
        bus.ram_wdata = bus.c_wdata;
      end
    end
  end

  assign bus.c_gnt   = c_gnt;
  assign bus.d_gnt   = d_gnt;
  assign bus.c_stall = bus.c_req & ~c_gnt;

  dmem_arb_rdreg u_c_rd (
    .clk      (clk),
    .rst      (rst),
    .gnt      (c_gnt),
    .we       (bus.c_we),
    .ram_rdata(bus.ram_rdata),
    .rdata    (bus.c_rdata),
    .rvalid   (bus.c_rvalid)
  );

  dmem_arb_rdreg u_d_rd (
    .clk      (clk),
    .rst      (rst),
    .gnt      (d_gnt),
    .we       (bus.d_we),
    .ram_rdata(bus.ram_rdata),
    .rdata    (bus.d_rdata),
    .rvalid   (bus.d_rvalid)
  );

`ifdef DMEM_ARB_STATS_EN
  // Free-running wrapping usage counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_c_grants  <= 32'd0;
      stat_d_grants  <= 32'd0;
      stat_conflicts <= 32'd0;
    end else begin
      if (c_gnt) stat_c_grants <= stat_c_grants + 32'd1;
      if (d_gnt) stat_d_grants <= stat_d_grants + 32'd1;
      if (bus.c_req && bus.d_req) stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized traffic, checked against a behavioural arbitration model and a
// reference memory image; read data goes through a scoreboard queue per port.
module tb_dmem_arbiter;

  localparam int ADDR_W   = 14;
  localparam int LEN_W    = 4;
  localparam int MAX_WAIT = 8;
  localparam int DEPTH    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_c_grants, stat_d_grants, stat_conflicts;
`endif

  dmem_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_c_grants (stat_c_grants),
    .stat_d_grants (stat_d_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );

  // RAM array driven only by the DUT's RAM bus
  bit [31:0] ram [DEPTH];
  assign bus.ram_rdata = ram[bus.ram_addr];
  always @(posedge clk) begin
    if (bus.ram_en && bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
  end

  // Reference memory image and behavioural arbitration model
  bit [31:0]   ref_mem [DEPTH];
  logic [31:0] c_q[$];
  logic [31:0] d_q[$];
  bit          m_lock;
  int          m_remaining;
  int          m_waited;
  bit          last_c_gnt, last_d_gnt;
  int          n_c_gnt, n_d_gnt, n_conf;
  int          checks = 0;
  int          failures = 0;

  function automatic int wordOf(input logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: predict this cycle's grant from the arbitration rules, check the bus
  always @(negedge clk) begin
    bit eg_c, eg_d;
    int w;
    logic [63:0] exp_bus, act_bus;
    eg_c = 1'b0;
    eg_d = 1'b0;
    if (rst) begin
      m_lock = 1'b0; m_remaining = 0; m_waited = 0;
      n_c_gnt = 0; n_d_gnt = 0; n_conf = 0;
    end else begin
      if (m_lock) begin
        if (bus.d_req) eg_d = 1'b1;
        else if (bus.c_req) eg_c = 1'b1;
      end else begin
        if (bus.d_req && m_waited >= MAX_WAIT) eg_d = 1'b1;
        else if (bus.c_req) eg_c = 1'b1;
        else if (bus.d_req) eg_d = 1'b1;
      end
      if (eg_d) begin
        if (m_lock) begin
          m_remaining = m_remaining - 1;
          if (m_remaining == 0) m_lock = 1'b0;
        end else if (int'(bus.d_len) > 0) begin
          m_lock = 1'b1;
          m_remaining = int'(bus.d_len);
        end
      end
      m_waited = (bus.d_req && !eg_d) ? ((m_waited + 1 > MAX_WAIT) ? MAX_WAIT : m_waited + 1) : 0;
      if (eg_c) n_c_gnt++;
      if (eg_d) n_d_gnt++;
      if (bus.c_req && bus.d_req) n_conf++;
    end
    checkOutput("c_gnt", 64'(bus.c_gnt), 64'(eg_c));
    checkOutput("d_gnt", 64'(bus.d_gnt), 64'(eg_d));
    checkOutput("c_stall", 64'(bus.c_stall), 64'(bus.c_req && !eg_c));
    exp_bus = 64'd0;
    if (eg_c) begin
      w = wordOf(bus.c_addr);
      exp_bus = {16'd0, 1'b1, bus.c_we, 14'(w), bus.c_wdata};
      if (bus.c_we) ref_mem[w] = bus.c_wdata;
      else c_q.push_back(ref_mem[w]);
    end else if (eg_d) begin
      w = wordOf(bus.d_addr);
      exp_bus = {16'd0, 1'b1, bus.d_we, 14'(w), bus.d_wdata};
      if (bus.d_we) ref_mem[w] = bus.d_wdata;
      else d_q.push_back(ref_mem[w]);
    end
    act_bus = {16'd0, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata};
    checkOutput("ram_bus", act_bus, exp_bus);
    last_c_gnt = eg_c;
    last_d_gnt = eg_d;
  end

  // Monitor: read responses are popped from the scoreboard after each edge
  always @(posedge clk) begin
    #3;
    if (rst) begin
      checkOutput("rst_rd", {bus.c_rvalid, bus.d_rvalid, bus.c_rdata, bus.d_rdata}, 64'd0);
    end else begin
      checkOutput("c_rvalid", 64'(bus.c_rvalid), 64'(c_q.size() > 0));
      if (c_q.size() > 0) begin
        if (bus.c_rvalid) checkOutput("c_rdata", 64'(bus.c_rdata), 64'(c_q[0]));
        void'(c_q.pop_front());
      end
      checkOutput("d_rvalid", 64'(bus.d_rvalid), 64'(d_q.size() > 0));
      if (d_q.size() > 0) begin
        if (bus.d_rvalid) checkOutput("d_rdata", 64'(bus.d_rdata), 64'(d_q[0]));
        void'(d_q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                               input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd,
                               input logic [LEN_W-1:0] dl);
    @(posedge clk);
    #1;
    bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
    bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd; bus.d_len = dl;
  endtask

  task automatic applyReset(input bit v);
    @(posedge clk);
    #1;
    rst = v;
    if (v) begin
      c_q.delete();
      d_q.delete();
    end
  endtask

  function automatic logic [31:0] randAddr();
    return ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    int diffs;
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_len = 0;
    repeat (2) @(posedge clk);
    applyReset(0);

    // Preload word 5 through port D, then a plain CPU read of 0x14
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h14, 32'hDEADBEEF, 0);
    applyStimulus(1, 0, 32'h14, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Conflict: CPU wins, DMA follows once CPU drops
    applyStimulus(1, 0, 32'h20, 0, 1, 0, 32'h14, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h14, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Starvation: DMA overrides on the ninth contested cycle
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 32'(i * 4), 0, 1, 0, 32'h14, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Four-beat DMA write burst with a hole taken by the CPU
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h100, 32'hA0, 3);
    applyStimulus(1, 0, 32'h104, 0, 1, 1, 32'h104, 32'hA1, 0);
    applyStimulus(1, 0, 32'h104, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 32'h108, 0, 1, 1, 32'h108, 32'hA2, 0);
    applyStimulus(1, 0, 32'h108, 0, 1, 1, 32'h10C, 32'hA3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a burst, CPU granted right after release
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h200, 32'hB0, 3);
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h204, 32'hB1, 0);
    applyReset(1);
    applyStimulus(1, 0, 32'h104, 0, 1, 1, 32'h208, 32'hB2, 0);
    applyReset(0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Address wrap: bit 16 is outside the RAM, so this lands on word 1
    applyStimulus(1, 1, 32'h0001_0004, 32'h1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 32'h4, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic obeying the hold-until-granted rule
    for (int n = 0; n < 3000; n++) begin
      bit cr, cw, dr, dw;
      logic [31:0] ca, cd, da, dd;
      logic [LEN_W-1:0] dl;
      if ($urandom_range(0, 599) == 0) begin
        applyReset(1);
        applyReset(0);
      end
      if (bus.c_req && !last_c_gnt) begin
        cr = 1; cw = bus.c_we; ca = bus.c_addr; cd = bus.c_wdata;
      end else begin
        cr = ($urandom_range(0, 9) < 6); cw = $urandom_range(0, 1) == 1; ca = randAddr(); cd = $urandom;
      end
      if (bus.d_req && !last_d_gnt) begin
        dr = 1; dw = bus.d_we; da = bus.d_addr; dd = bus.d_wdata; dl = bus.d_len;
      end else begin
        dr = $urandom_range(0, 1) == 1; dw = $urandom_range(0, 1) == 1; da = randAddr(); dd = $urandom;
        dl = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(1, 15)) : '0;
      end
      applyStimulus(cr, cw, ca, cd, dr, dw, da, dd, dl);
    end

    // Drain: let any lock finish, then compare the whole memory image
    for (int n = 0; n < 40; n++) applyStimulus(0, 0, 0, 0, 1, 0, 32'h0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] != ref_mem[i]) diffs++;
    checkOutput("mem_image", 64'(diffs), 64'd0);
    checkOutput("word5", 64'(ram[5]), 64'(ref_mem[5]));
`ifdef DMEM_ARB_STATS_EN
    checkOutput("stat_c", 64'(stat_c_grants), 64'(n_c_gnt));
    checkOutput("stat_d", 64'(stat_d_grants), 64'(n_d_gnt));
    checkOutput("stat_conf", 64'(stat_conflicts), 64'(n_conf));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between the RV32iPCPU load/store port (port C) and a DMA/debug loader port (port D).
- Arbitrates per cycle with fixed CPU priority, a DMA anti-starvation override, and DMA burst locking.
- Sits between the CPU's ALU_out/data_out/mem_w/RAM_data_in signals and the Data_RAM array.
- RAM read is combinational, RAM write commits on the clock edge.

Parameters:
- ADDR_W, 14, RAM word-address width (byte address bits [ADDR_W+1:2] used).
- LEN_W, 4, DMA burst-length field width.
- MAX_WAIT, 8, consecutive DMA-denied cycles before the DMA override fires (legal range 1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- c_req  in  1  CPU access request
- c_we  in  1  CPU write enable
- c_addr  in  32  CPU byte address
- c_wdata  in  32  CPU write data
- c_gnt  out  1  CPU access performed this cycle
- c_stall  out  1  c_req & ~c_gnt
- c_rdata  out  32  registered read data
- c_rvalid  out  1  c_rdata valid
- d_req  in  1  DMA beat request
- d_we  in  1  DMA write enable
- d_addr  in  32  DMA byte address
- d_wdata  in  32  DMA write data
- d_len  in  LEN_W  burst beats minus 1, sampled on the first granted beat
- d_gnt  out  1  DMA beat performed this cycle
- d_rdata  out  32  registered read data
- d_rvalid  out  1  d_rdata valid
- ram_en  out  1  RAM access this cycle
- ram_we  out  1  RAM write
- ram_addr  out  ADDR_W  word address
- ram_wdata  out  32  write data
- ram_rdata  in  32  combinational RAM read data

Behaviour:
- Reset (async, active-high):
  - state=IDLE; beats_left=0; wait_cnt=0.
  - All registered outputs 0: c_rdata, d_rdata, c_rvalid, d_rvalid.
  - A burst in flight is aborted. No RAM write may occur while rst=1.
- Grant outputs (c_gnt, d_gnt, ram_*) are combinational from the current state and requests.
  - At most one gnt per cycle.
  - ram_en = c_gnt | d_gnt.
  - ram_* is muxed from the granted port. ram_* is 0 when neither port is granted.
- Write: the RAM commits at the clock edge that ends the grant cycle.
- Read: ram_rdata is captured into x_rdata at that edge. x_rvalid=1 for exactly the following cycle (latency 1), and 0 after writes.
- Requesters hold req/addr/we/wdata stable until they see gnt.
- States:
  - IDLE:
    - Priority: if wait_cnt==MAX_WAIT and d_req, grant D; else if c_req, grant C; else if d_req, grant D.
    - A D grant with d_len>0 loads beats_left=d_len and moves to DLOCK.
    - A D grant with d_len==0 is a single beat and stays in IDLE.
  - DLOCK:
    - d_req=1: grant D; beats_left decrements; go to IDLE when beats_left reaches 0 after this beat.
    - d_req=0: hole cycle. Grant C if c_req; beats_left is unchanged.
    - d_len is ignored in DLOCK.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) on each cycle with d_req & ~d_gnt.
  - Clears on any d_gnt or whenever d_req=0.
- Boundaries:
  - Simultaneous c_req and d_req in IDLE with wait_cnt<MAX_WAIT: C wins and wait_cnt increments.
  - Override fires the cycle wait_cnt==MAX_WAIT.
  - Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the RAM size. Bits [1:0] are ignored.
  - Back-to-back reads by the same port: rvalid remains high each cycle.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, adds outputs stat_c_grants[31:0], stat_d_grants[31:0], stat_conflicts[31:0].
  - stat_conflicts counts cycles with c_req & d_req.
  - All three are free-running wrapping counters, reset to 0.
- When undefined, those ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum {IDLE, DLOCK};
  - port-select constants PORT_C=0, PORT_D=1;
  - default MAX_WAIT.
- One sub-module, dmem_arb_rdreg: per-port read-data/rvalid register pair, instantiated twice.

Test Plan:
- CPU read only: preload RAM[5]=32'hDEADBEEF; c_req, c_we=0, c_addr=0x14 -> c_gnt same cycle; next cycle c_rvalid=1, c_rdata=DEADBEEF; c_stall=0.
- Conflict: c_req and d_req in IDLE with wait_cnt=0 -> c_gnt=1, d_gnt=0; after c_req drops, d_gnt=1 next cycle.
- Starvation: c_req held high continuously, d_req high, MAX_WAIT=8 -> d_gnt on the 9th cycle; c_stall=1 that cycle only.
- Burst with hole: d_len=3, DMA writes 0x100.. with d_req low on beat 2 while c_req high -> 4 D beats total; C granted in the hole; RAM words 0x40..0x43 written; state back to IDLE.
- Reset mid-burst: assert rst after 2 of 4 beats -> all outputs 0 immediately; no RAM write during rst; after release, c_req is granted at once.
- Wrap: c_addr=0x0001_0004 write 0x1 -> RAM word 1 written (ADDR_W=14).
